nonogram_stream_parser: RTL and testbench

- Parametrised parser for the host-to-FPGA nonogram constraint byte stream.
- Assembles byte pairs into 16-bit words (3-bit flag, 13-bit payload) and extracts the board dimensions.
- Emits clause-literal writes to the constraint BRAM using row/column addressing, with write backpressure and protocol-error detection.
- Sits between the UART receiver and the constraint BRAM, feeding the solver.

---
 rtl/nonogram_stream_parser.sv | 183 ++++++++++++++++++
 tb/tb_nonogram_stream_parser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_stream_parser.sv
// nonogram_stream_parser: turns the host nonogram constraint byte stream into clause-literal BRAM writes.
// Ports:
//   clk, rst                              clock, synchronous active-low reset
//   byte_in, valid_in, ready_in           incoming byte stream handshake
//   wr_valid, wr_ready, wr_addr, wr_data  constraint BRAM write port
//   n, m, dims_valid                      board rows/columns once the header is accepted
//   board_done                            board parsed without error
//   error, error_code                     sticky protocol error and its first cause
module nonogram_stream_parser #(
    parameter int DIM_W    = 12,
    parameter int ASSIGN_W = 13,
    parameter int ADDR_W   = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                valid_in,
    output logic                ready_in,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ASSIGN_W-1:0] wr_data,
    output logic [DIM_W-1:0]    n,
    output logic [DIM_W-1:0]    m,
    output logic                dims_valid,
    output logic                board_done,
    output logic                error,
    output logic [2:0]          error_code
);
    localparam logic [2:0] S_IDLE = 3'd0, S_HDR_M = 3'd1, S_BODY = 3'd2, S_DONE = 3'd3, S_ERROR = 3'd4;
    localparam logic [2:0] F_START_BOARD = 3'b111, F_START_LINE = 3'b110, F_AND = 3'b101;
    localparam logic [2:0] F_OR = 3'b010, F_END_LINE = 3'b001, F_END_BOARD = 3'b000;
    // Wide enough to hold DEPTH itself and row_base + stride without wrapping.
    localparam int AW = (ADDR_W > DIM_W ? ADDR_W : DIM_W) + 2;
    localparam logic [AW-1:0] DEPTH = AW'(1) << ADDR_W;

    logic [2:0]          state;
    logic                phase;
    logic [7:0]          hi_byte;
    logic [DIM_W:0]      stride, col, line_index;
    logic [ADDR_W-1:0]   row_base;
    logic                line_open;
    logic                word_done;
    logic [2:0]          flag;
    logic [12:0]         payload;
    logic [DIM_W-1:0]    new_m;
    logic [DIM_W:0]      new_stride;
    logic [AW-1:0]       rb_next;
    logic [2:0]          err;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [ASSIGN_W-1:0] data;

    assign ready_in   = !wr_valid || wr_ready;
    // The low byte completes the word and is decoded straight off byte_in.
    assign word_done  = valid_in && ready_in && phase;
    assign flag       = hi_byte[7:5];
    assign payload    = {hi_byte[4:0], byte_in};
    assign new_m      = payload[DIM_W-1:0];
    assign new_stride = {1'b0, (n > new_m) ? n : new_m} + (DIM_W+1)'(1);
    assign rb_next    = AW'(row_base) + AW'(stride);

    // Decode the completing word into an error cause (0 = none) and an optional write.
    always_comb begin
        err  = 3'd0;
        wr   = 1'b0;
        addr = row_base;
        data = ASSIGN_W'(line_index);
        if (word_done && state == S_HDR_M) begin
            if (flag != F_START_BOARD)
                err = 3'd4;
            else if (n == '0 || new_m == '0 || AW'(new_stride) > DEPTH)
                err = 3'd1;
        end else if (word_done && state == S_BODY) begin
            case (flag)
                F_START_LINE: if (line_open) err = 3'd5; else wr = 1'b1;
                F_AND: begin
                    if (!line_open)
                        err = 3'd5;
                    else if (col == stride)
                        err = 3'd2;
                    else begin
                        wr   = 1'b1;
                        addr = row_base + ADDR_W'(col);
                        data = payload[ASSIGN_W-1:0];
                    end
                end
                F_OR: begin
                    if (!line_open)
                        err = 3'd5;
                    else if (rb_next >= DEPTH)
                        err = 3'd3;
                    else begin
                        wr   = 1'b1;
                        addr = rb_next[ADDR_W-1:0];
                    end
                end
                F_END_LINE: err = !line_open ? 3'd5 : (rb_next >= DEPTH) ? 3'd3 : 3'd0;
                F_END_BOARD: err = (line_open || line_index != ({1'b0, n} + {1'b0, m})) ? 3'd6 : 3'd0;
                F_START_BOARD: err = 3'd0;
                default: err = 3'd4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            hi_byte    <= '0;
            stride     <= '0;
            col        <= '0;
            line_index <= '0;
            row_base   <= '0;
            line_open  <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            n          <= '0;
            m          <= '0;
            dims_valid <= 1'b0;
            board_done <= 1'b0;
            error      <= 1'b0;
            error_code <= 3'd0;
        end else begin
            if (valid_in && ready_in) begin
                phase   <= !phase;
                hi_byte <= byte_in;
            end
            if (wr) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= data;
            end else if (wr_ready)
                wr_valid <= 1'b0;
            if (err != 3'd0) begin
                state      <= S_ERROR;
                error      <= 1'b1;
                error_code <= err;
            end else if (word_done && flag == F_START_BOARD && state != S_HDR_M) begin
                // Start (or resync to) a new board from any state.
                n          <= payload[DIM_W-1:0];
                board_done <= 1'b0;
                dims_valid <= 1'b0;
                error      <= 1'b0;
                error_code <= 3'd0;
                line_index <= '0;
                state      <= S_HDR_M;
            end else if (word_done && state == S_HDR_M) begin
                m          <= new_m;
                stride     <= new_stride;
                dims_valid <= 1'b1;
                row_base   <= '0;
                col        <= '0;
                line_open  <= 1'b0;
                state      <= S_BODY;
            end else if (word_done && state == S_BODY) begin
                case (flag)
                    F_START_LINE: begin
                        col       <= (DIM_W+1)'(1);
                        line_open <= 1'b1;
                    end
                    F_AND: col <= col + (DIM_W+1)'(1);
                    F_OR: begin
                        row_base <= rb_next[ADDR_W-1:0];
                        col      <= (DIM_W+1)'(1);
                    end
                    F_END_LINE: begin
                        row_base   <= rb_next[ADDR_W-1:0];
                        col        <= '0;
                        line_index <= line_index + (DIM_W+1)'(1);
                        line_open  <= 1'b0;
                    end
                    F_END_BOARD: begin
                        board_done <= 1'b1;
                        state      <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nonogram_stream_parser.sv
// tb_nonogram_stream_parser: scoreboard bench for nonogram_stream_parser on 2x2 and 2x3 boards.
module tb_nonogram_stream_parser;
    localparam int DIM_W = 12, ASSIGN_W = 13, ADDR_W = 26, RW = ADDR_W + ASSIGN_W;

    logic                clk = 1'b0, rst = 1'b0;
    logic [7:0]          byte_in = '0;
    logic                valid_in = 1'b0, wr_ready = 1'b1;
    logic                ready_in, wr_valid, dims_valid, board_done, error;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ASSIGN_W-1:0] wr_data;
    logic [DIM_W-1:0]    n, m;
    logic [2:0]          error_code;
    int                  tests = 0, fails = 0;
    logic [RW-1:0]       exp_q[$], got_q[$];
    logic [RW-1:0]       e, g;

    nonogram_stream_parser dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in), .ready_in(ready_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .n(n), .m(m), .dims_valid(dims_valid), .board_done(board_done),
        .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    // Record every completed BRAM write; it retires at the following rising edge.
    always @(negedge clk) if (rst && wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst = 1'b0; valid_in = 1'b0; byte_in = '0; wr_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        byte_in = b; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && k < 50) begin k++; @(negedge clk); end
        if (!ready_in) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout: ready_in=%0b after %0d cycles, required 1", ready_in, k);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic header(input int rows, input int cols);
        send_word({3'b111, 13'(rows)});
        send_word({3'b111, 13'(cols)});
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_q.push_back({ADDR_W'(a), ASSIGN_W'(d)});
    endtask

    task automatic settle;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({wr_valid, wr_addr, wr_data, n, m, dims_valid, board_done, error, error_code} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: wr_valid=%0b addr=%0d data=%0d n=%0d m=%0d dv=%0b done=%0b err=%0b code=%0d, required all 0",
                     wr_valid, wr_addr, wr_data, n, m, dims_valid, board_done, error, error_code);
        end
        tests++;
        if (ready_in !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b required 1", ready_in); end
    endtask

    task automatic test_lines;
        do_reset();
        header(2, 2);
        tests++;
        if ({dims_valid, n, m} !== {1'b1, 12'd2, 12'd2}) begin
            fails++; $display("FAIL lines_dims: dv=%0b n=%0d m=%0d required 1 2 2", dims_valid, n, m);
        end
        expect_wr(0, 0); expect_wr(1, 5); expect_wr(3, 0); expect_wr(4, 9);
        send_word(16'hC000); send_word(16'hA005); send_word(16'h4000); send_word(16'hA009); send_word(16'h2000);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL lines_count: got %0d writes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL lines_write: got (%0d,%0d) required (%0d,%0d)", g[RW-1:ASSIGN_W], g[ASSIGN_W-1:0], e[RW-1:ASSIGN_W], e[ASSIGN_W-1:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // Continues the board left open by test_lines: row_base=6, line_index=1.
    task automatic test_board_done;
        expect_wr(6, 1); expect_wr(7, 1); expect_wr(9, 2); expect_wr(10, 1); expect_wr(12, 3); expect_wr(13, 1);
        for (int i = 0; i < 3; i++) begin
            send_word(16'hC000); send_word(16'hA001); send_word(16'h2000);
        end
        tests++;
        if (board_done !== 1'b0) begin fails++; $display("FAIL done_early: board_done=%0b required 0", board_done); end
        send_word(16'h0000);
        tests++;
        if ({board_done, error, dims_valid} !== 3'b101) begin
            fails++; $display("FAIL done_flags: done=%0b err=%0b dv=%0b required 1 0 1", board_done, error, dims_valid);
        end
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL done_count: got %0d writes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL done_write: got (%0d,%0d) required (%0d,%0d)", g[RW-1:ASSIGN_W], g[ASSIGN_W-1:0], e[RW-1:ASSIGN_W], e[ASSIGN_W-1:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_early_end;
        do_reset();
        header(2, 2);
        for (int i = 0; i < 3; i++) begin
            send_word(16'hC000); send_word(16'hA001); send_word(16'h2000);
        end
        send_word(16'h0000);
        tests++;
        if ({error, error_code, board_done} !== {1'b1, 3'd6, 1'b0}) begin
            fails++; $display("FAIL early_end: err=%0b code=%0d done=%0b required 1 6 0", error, error_code, board_done);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        header(2, 2);
        expect_wr(0, 0); expect_wr(1, 5); expect_wr(3, 0);
        send_word(16'hC000);
        settle();
        wr_ready = 1'b0;
        send_word(16'hA005);
        byte_in = 8'h40; valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({ready_in, wr_valid, wr_addr, wr_data} !== {1'b0, 1'b1, 26'd1, 13'd5}) begin
                fails++; $display("FAIL stall_hold: ready=%0b wv=%0b addr=%0d data=%0d required 0 1 1 5", ready_in, wr_valid, wr_addr, wr_data);
            end
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({ready_in, wr_valid} !== 2'b11) begin fails++; $display("FAIL stall_release: ready=%0b wv=%0b required 1 1", ready_in, wr_valid); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        tests++;
        if (wr_valid !== 1'b0) begin fails++; $display("FAIL stall_retire: wv=%0b required 0", wr_valid); end
        send_byte(8'h00);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_count: got %0d writes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL stall_write: got (%0d,%0d) required (%0d,%0d)", g[RW-1:ASSIGN_W], g[ASSIGN_W-1:0], e[RW-1:ASSIGN_W], e[ASSIGN_W-1:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_col_overflow;
        do_reset();
        header(2, 2);
        expect_wr(0, 0); expect_wr(1, 1); expect_wr(2, 2);
        send_word(16'hC000); send_word(16'hA001); send_word(16'hA002); send_word(16'hA003);
        tests++;
        if ({error, error_code} !== {1'b1, 3'd2}) begin fails++; $display("FAIL col_error: err=%0b code=%0d required 1 2", error, error_code); end
        send_byte(8'h12); send_byte(8'h34);
        tests++;
        if ({ready_in, error, error_code} !== {1'b1, 1'b1, 3'd2}) begin
            fails++; $display("FAIL col_sticky: ready=%0b err=%0b code=%0d required 1 1 2", ready_in, error, error_code);
        end
        header(2, 3);
        tests++;
        if ({error, dims_valid, n, m} !== {1'b0, 1'b1, 12'd2, 12'd3}) begin
            fails++; $display("FAIL col_recover: err=%0b dv=%0b n=%0d m=%0d required 0 1 2 3", error, dims_valid, n, m);
        end
        expect_wr(0, 0); expect_wr(4, 0);
        send_word(16'hC000); send_word(16'h4000);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL col_count: got %0d writes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL col_write: got (%0d,%0d) required (%0d,%0d)", g[RW-1:ASSIGN_W], g[ASSIGN_W-1:0], e[RW-1:ASSIGN_W], e[ASSIGN_W-1:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_protocol;
        do_reset();
        header(2, 2);
        send_word(16'hA001);
        settle();
        tests++;
        if ({error, error_code} !== {1'b1, 3'd5} || got_q.size() != 0) begin
            fails++; $display("FAIL proto_line_state: err=%0b code=%0d writes=%0d required 1 5 0", error, error_code, got_q.size());
        end
        do_reset();
        header(2, 2);
        send_word(16'h6000);
        tests++;
        if ({error, error_code} !== {1'b1, 3'd4}) begin fails++; $display("FAIL proto_illegal: err=%0b code=%0d required 1 4", error, error_code); end
        do_reset();
        header(0, 2);
        tests++;
        if ({error, error_code, dims_valid} !== {1'b1, 3'd1, 1'b0}) begin
            fails++; $display("FAIL proto_dims: err=%0b code=%0d dv=%0b required 1 1 0", error, error_code, dims_valid);
        end
        do_reset();
        send_word(16'hE002); send_word(16'hC000);
        tests++;
        if ({error, error_code} !== {1'b1, 3'd4}) begin fails++; $display("FAIL proto_hdr: err=%0b code=%0d required 1 4", error, error_code); end
    endtask

    task automatic test_reset_midword;
        do_reset();
        header(2, 2);
        send_word(16'hC000);
        send_byte(8'hA0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        got_q.delete();
        tests++;
        if ({wr_valid, wr_addr, wr_data, n, m, dims_valid, board_done, error, error_code} !== '0) begin
            fails++; $display("FAIL midword_reset: wv=%0b n=%0d m=%0d dv=%0b err=%0b required all 0", wr_valid, n, m, dims_valid, error);
        end
        send_byte(8'h05); send_byte(8'h00);
        settle();
        tests++;
        if ({dims_valid, error, n} !== '0 || got_q.size() != 0) begin
            fails++; $display("FAIL midword_drop: dv=%0b err=%0b n=%0d writes=%0d required 0 0 0 0", dims_valid, error, n, got_q.size());
        end
        header(2, 2);
        expect_wr(0, 0);
        send_word(16'hC000);
        settle();
        tests++;
        if (dims_valid !== 1'b1 || got_q.size() != 1) begin
            fails++; $display("FAIL midword_realign: dv=%0b writes=%0d required 1 1", dims_valid, got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL midword_write: got (%0d,%0d) required (%0d,%0d)", g[RW-1:ASSIGN_W], g[ASSIGN_W-1:0], e[RW-1:ASSIGN_W], e[ASSIGN_W-1:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_lines();
        test_board_done();
        test_early_end();
        test_back_to_back();
        test_col_overflow();
        test_protocol();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
